// File: rtl/rt_pkg.sv
// ---------------------------------------------------------------------------
// rt_pkg
//   Shared definitions for the ray generation front end: the fixed-point
//   format used on the RGU coordinate bus, the tag that travels alongside each
//   issued pixel, and the pixel scheduler state encoding.
// ---------------------------------------------------------------------------
package rt_pkg;

  localparam int RT_FRAC_BITS   = 18;
  localparam int RT_DATA_W      = 32;
  localparam int RT_DIM_W       = 12;
  localparam int RT_RGU_LATENCY = 5;

  // 1.0 in the RGU fixed-point format
  localparam logic [31:0] Q_ONE = 32'(1) << RT_FRAC_BITS;

  // Tag carried through the FIFO for every pixel handed to the RGU
  typedef struct packed {
    logic [RT_DIM_W-1:0] x;
    logic [RT_DIM_W-1:0] y;
    logic                last;
  } pix_tag_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } sched_state_e;

  // Two spare entries over the RGU latency cover the one-cycle register on
  // each side of the RGU, so the tag FIFO never fills in legal operation.
  function automatic int tag_fifo_depth(input int rgu_latency);
    return rgu_latency + 2;
  endfunction

endpackage

// File: rtl/rt_tag_fifo.sv
// ---------------------------------------------------------------------------
// rt_tag_fifo
//   Synchronous FIFO of pix_tag_t. Any depth >= 1 (need not be a power of 2).
//   A push while full or a pop while empty is ignored; the parent decides
//   whether that is an error. pop_data shows the head entry combinationally.
// Ports
//   clk, resetn   clock, asynchronous active-low reset
//   push          write push_data this cycle
//   push_data     tag to store
//   pop           remove the head entry this cycle
//   pop_data      current head entry (valid while !empty)
//   empty, full   occupancy flags
// ---------------------------------------------------------------------------
module rt_tag_fifo
  import rt_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     push,
  input  pix_tag_t push_data,
  input  logic     pop,
  output pix_tag_t pop_data,
  output logic     empty,
  output logic     full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  pix_tag_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  // Pointers wrap explicitly because the depth is usually not a power of two
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push and pop in one cycle cancel out
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while the count says valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rt_pixel_scheduler.sv
// ---------------------------------------------------------------------------
// rt_pixel_scheduler
//   Front end of the ray generation unit. Walks the image raster row-major,
//   issuing one pixel per enabled cycle to the RGU as fixed-point x/y, and
//   tags each issue so the RGU's in-order results can be re-associated with
//   their integer pixel coordinate and a last-pixel flag.
// Ports
//   clk, resetn             clock, asynchronous active-low reset
//   cfg_width, cfg_height   image size, sampled on an accepted frame_start
//   frame_start             pulse: begin a frame (ignored while busy)
//   frame_abort             stop issuing; pixels already issued still drain
//   issue_en                downstream can take new work this cycle
//   busy                    frame in progress, until frame_done
//   frame_done              pulse when the frame has fully drained
//   tag_err                 sticky: result without a tag, or tag overflow
//   rgu_start, rgu_x, rgu_y issue strobe and fixed-point coordinate
//   rgu_valid               RGU result valid, in issue order
//   pix_valid, pix_x,
//   pix_y, pix_last         returned pixel, registered one cycle after rgu_valid
// ---------------------------------------------------------------------------
module rt_pixel_scheduler
  import rt_pkg::*;
#(
  parameter int FRAC_BITS   = RT_FRAC_BITS,
  parameter int DATA_W      = RT_DATA_W,
  parameter int DIM_W       = RT_DIM_W,
  parameter int RGU_LATENCY = RT_RGU_LATENCY
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic              frame_start,
  input  logic              frame_abort,
  input  logic              issue_en,
  output logic              busy,
  output logic              frame_done,
  output logic              tag_err,
  output logic              rgu_start,
  output logic [DATA_W-1:0] rgu_x,
  output logic [DATA_W-1:0] rgu_y,
  input  logic              rgu_valid,
  output logic              pix_valid,
  output logic [DIM_W-1:0]  pix_x,
  output logic [DIM_W-1:0]  pix_y,
  output logic              pix_last
);

  // The shifted index must fit in the coordinate word, and the tag struct
  // and Q format are shared with the intersector through the package.
  if (DIM_W + FRAC_BITS > DATA_W) begin : g_width_check
    $error("rt_pixel_scheduler: DIM_W + FRAC_BITS exceeds DATA_W");
  end
  if (DIM_W != RT_DIM_W || Q_ONE != (32'(1) << FRAC_BITS)) begin : g_pkg_check
    $error("rt_pixel_scheduler: DIM_W/FRAC_BITS disagree with rt_pkg");
  end

  sched_state_e      state;
  logic [DIM_W-1:0]  x_cnt;
  logic [DIM_W-1:0]  y_cnt;
  logic [DIM_W-1:0]  x_max;
  logic [DIM_W-1:0]  y_max;

  logic              do_issue;
  logic              is_last;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  pix_tag_t          push_tag;
  pix_tag_t          head_tag;

  function automatic logic [DATA_W-1:0] to_fixed(input logic [DIM_W-1:0] idx);
    return DATA_W'(idx) << FRAC_BITS;
  endfunction

  // Issue decision and tag for the pixel currently addressed by the counters.
  // Abort wins over issue so nothing new leaves in the abort cycle.
  always_comb begin
    do_issue      = (state == ISSUE) && issue_en && !frame_abort;
    is_last       = (x_cnt == x_max) && (y_cnt == y_max);
    push_tag      = '0;
    push_tag.x    = x_cnt;
    push_tag.y    = y_cnt;
    push_tag.last = is_last;
    fifo_push     = do_issue && !fifo_full;
    fifo_pop      = rgu_valid && !fifo_empty;
  end

  rt_tag_fifo #(
    .DEPTH (tag_fifo_depth(RGU_LATENCY))
  ) u_tag_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (push_tag),
    .pop       (fifo_pop),
    .pop_data  (head_tag),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Frame sequencing. A zero-sized frame goes straight to DRAIN with an
  // empty FIFO, which yields busy for one cycle followed by frame_done.
  // The counters hold max-index values so the wrap test is a plain compare.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      rgu_start  <= 1'b0;
      rgu_x      <= '0;
      rgu_y      <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      x_max      <= '0;
      y_max      <= '0;
    end else begin
      frame_done <= 1'b0;
      rgu_start  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            busy  <= 1'b1;
            x_cnt <= '0;
            y_cnt <= '0;
            x_max <= cfg_width - DIM_W'(1);
            y_max <= cfg_height - DIM_W'(1);
            if (cfg_width != '0 && cfg_height != '0) state <= ISSUE;
            else                                     state <= DRAIN;
          end
        end
        ISSUE: begin
          if (frame_abort) begin
            state <= DRAIN;
          end else if (issue_en) begin
            rgu_start <= 1'b1;
            rgu_x     <= to_fixed(x_cnt);
            rgu_y     <= to_fixed(y_cnt);
            if (is_last) begin
              state <= DRAIN;
            end else if (x_cnt == x_max) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + DIM_W'(1);
            end else begin
              x_cnt <= x_cnt + DIM_W'(1);
            end
          end
        end
        DRAIN: begin
          if (fifo_empty && !rgu_valid) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return path: every RGU result consumes one tag and is presented a cycle
  // later. A result with no tag, or an issue the FIFO cannot hold, latches
  // tag_err until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_last  <= 1'b0;
      tag_err   <= 1'b0;
    end else begin
      pix_valid <= fifo_pop;
      if (fifo_pop) begin
        pix_x    <= head_tag.x;
        pix_y    <= head_tag.y;
        pix_last <= head_tag.last;
      end
      if ((rgu_valid && fifo_empty) || (do_issue && fifo_full)) tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rt_pixel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rt_pixel_scheduler
//   Scoreboard bench: each frame's expected pixel sequence is produced from a
//   plain raster model; an issue monitor checks the RGU coordinates and feeds
//   the return queue, a return monitor checks the tagged pixels.
// ---------------------------------------------------------------------------
module tb_rt_pixel_scheduler;

  localparam int Q      = 1 << 18;
  localparam int DIM_W  = 12;
  localparam int DATA_W = 32;

  typedef struct {
    int x;
    int y;
    int last;
  } exp_t;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [DIM_W-1:0]  cfg_width = '0;
  logic [DIM_W-1:0]  cfg_height = '0;
  logic              frame_start = 1'b0;
  logic              frame_abort = 1'b0;
  logic              issue_en = 1'b0;
  logic              busy;
  logic              frame_done;
  logic              tag_err;
  logic              rgu_start;
  logic [DATA_W-1:0] rgu_x;
  logic [DATA_W-1:0] rgu_y;
  logic              rgu_valid = 1'b0;
  logic              pix_valid;
  logic [DIM_W-1:0]  pix_x;
  logic [DIM_W-1:0]  pix_y;
  logic              pix_last;

  logic              inject = 1'b0;
  logic [3:0]        rgu_pipe = '0;

  exp_t exp_issue[$];
  exp_t exp_ret[$];
  int   errors = 0;
  int   checks = 0;
  int   start_count = 0;
  int   pix_count = 0;

  rt_pixel_scheduler dut (
    .clk         (clk),
    .resetn      (resetn),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .frame_start (frame_start),
    .frame_abort (frame_abort),
    .issue_en    (issue_en),
    .busy        (busy),
    .frame_done  (frame_done),
    .tag_err     (tag_err),
    .rgu_start   (rgu_start),
    .rgu_x       (rgu_x),
    .rgu_y       (rgu_y),
    .rgu_valid   (rgu_valid),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_last    (pix_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // RGU stand-in: a start returns as rgu_valid five cycles later
  always @(posedge clk) begin
    #1;
    if (!resetn) begin
      rgu_pipe  = '0;
      rgu_valid = 1'b0;
    end else begin
      rgu_valid = rgu_pipe[3] | inject;
      rgu_pipe  = {rgu_pipe[2:0], rgu_start};
    end
  end

  // Issue monitor: every start must carry the next raster coordinate
  always @(posedge clk) begin
    #1;
    if (resetn && rgu_start === 1'b1) begin
      start_count++;
      if (exp_issue.size() == 0) begin
        checkOutput("unexpected_start", 1, 0);
      end else begin
        exp_t e;
        e = exp_issue.pop_front();
        checkOutput("rgu_x", rgu_x, 64'(e.x * Q));
        checkOutput("rgu_y", rgu_y, 64'(e.y * Q));
        exp_ret.push_back(e);
      end
    end
  end

  // Return monitor: pixels come back tagged in issue order
  always @(posedge clk) begin
    #1;
    if (resetn && pix_valid === 1'b1) begin
      pix_count++;
      if (exp_ret.size() == 0) begin
        checkOutput("unexpected_pix", 1, 0);
      end else begin
        exp_t e;
        e = exp_ret.pop_front();
        checkOutput("pix_x", pix_x, 64'(e.x));
        checkOutput("pix_y", pix_y, 64'(e.y));
        checkOutput("pix_last", pix_last, 64'(e.last));
      end
    end
  end

  function automatic logic enFor(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3 == 0);
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic doReset();
    resetn      = 1'b0;
    inject      = 1'b0;
    frame_start = 1'b0;
    frame_abort = 1'b0;
    issue_en    = 1'b0;
    exp_issue.delete();
    exp_ret.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // One frame: mode 0 = always enabled, 1 = pattern 1,0,0, 2 = random.
  // abort_after >= 0 aborts once that many starts have been seen.
  task automatic applyStimulus(input int w, input int h, input int mode,
                               input int abort_after);
    int  cyc;
    int  abort_cyc;
    int  start_base;
    int  pix_base;
    int  starts_now;
    bit  done;
    bit  aborted;
    cyc = 0;
    abort_cyc = -1;
    done = 1'b0;
    aborted = 1'b0;
    exp_issue.delete();
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        exp_issue.push_back('{xx, yy, (xx == w - 1 && yy == h - 1) ? 1 : 0});
    @(negedge clk);
    start_base  = start_count;
    pix_base    = pix_count;
    cfg_width   = DIM_W'(w);
    cfg_height  = DIM_W'(h);
    frame_start = 1'b1;
    issue_en    = enFor(mode, 0);
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      frame_start = 1'b0;
      frame_abort = 1'b0;
      cfg_width   = DIM_W'($urandom);
      cfg_height  = DIM_W'($urandom);
      if (frame_done === 1'b1) begin
        done = 1'b1;
      end else begin
        issue_en = enFor(mode, cyc);
        if (abort_after >= 0 && !aborted && start_count - start_base >= abort_after) begin
          frame_abort = 1'b1;
          aborted     = 1'b1;
          abort_cyc   = cyc;
          exp_issue.delete();
        end else if (aborted && cyc == abort_cyc + 1) begin
          frame_start = 1'b1;
        end
      end
    end
    checkOutput("frame_done_seen", done, 1);
    if (!done) begin
      doReset();
      return;
    end
    checkOutput("busy_at_done", busy, 0);
    checkOutput("tag_err_clear", tag_err, 0);
    checkOutput("returns_drained", exp_ret.size(), 0);
    if (abort_after >= 0) begin
      checkOutput("abort_starts", start_count - start_base, abort_after);
      checkOutput("abort_pix", pix_count - pix_base, abort_after);
    end else begin
      checkOutput("frame_starts", start_count - start_base, w * h);
      checkOutput("issue_complete", exp_issue.size(), 0);
      checkOutput("frame_pix", pix_count - pix_base, w * h);
    end
    issue_en = 1'b0;
    starts_now = start_count;
    repeat (4) @(negedge clk);
    checkOutput("idle_after_done", busy, 0);
    checkOutput("no_starts_after_done", start_count - starts_now, 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0;
    repeat (2) @(negedge clk);
    checkOutput("reset_rgu_start", rgu_start, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_tag_err", tag_err, 0);
    checkOutput("reset_pix_valid", pix_valid, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] frame 4x1");
    applyStimulus(4, 1, 0, -1);
    $display("[TB] frame 3x2");
    applyStimulus(3, 2, 0, -1);
    $display("[TB] frame 10x2 with issue_en pattern");
    applyStimulus(10, 2, 1, -1);
    for (int i = 0; i < 4; i++) begin
      int rw;
      int rh;
      rw = $urandom_range(1, 6);
      rh = $urandom_range(1, 4);
      $display("[TB] random frame %0dx%0d", rw, rh);
      applyStimulus(rw, rh, 2, -1);
    end

    $display("[TB] zero-width frame");
    s0 = start_count;
    @(negedge clk);
    cfg_width   = '0;
    cfg_height  = DIM_W'(5);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    checkOutput("zero_busy", busy, 1);
    checkOutput("zero_done_early", frame_done, 0);
    @(negedge clk);
    checkOutput("zero_done", frame_done, 1);
    checkOutput("zero_busy_fall", busy, 0);
    @(negedge clk);
    checkOutput("zero_done_pulse", frame_done, 0);
    checkOutput("zero_starts", start_count - s0, 0);

    $display("[TB] abort after 3 issues");
    applyStimulus(8, 8, 0, 3);

    $display("[TB] spurious rgu_valid");
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    checkOutput("tag_err_set", tag_err, 1);
    checkOutput("spurious_no_pix", pix_valid, 0);
    @(negedge clk);
    checkOutput("tag_err_sticky", tag_err, 1);
    checkOutput("spurious_no_pix_late", pix_valid, 0);

    $display("[TB] reset mid-frame");
    exp_issue.delete();
    for (int yy = 0; yy < 8; yy++)
      for (int xx = 0; xx < 8; xx++)
        exp_issue.push_back('{xx, yy, (xx == 7 && yy == 7) ? 1 : 0});
    cfg_width   = DIM_W'(8);
    cfg_height  = DIM_W'(8);
    frame_start = 1'b1;
    issue_en    = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst_rgu_start", rgu_start, 0);
    checkOutput("rst_rgu_x", rgu_x, 0);
    checkOutput("rst_rgu_y", rgu_y, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_tag_err", tag_err, 0);
    checkOutput("rst_pix_valid", pix_valid, 0);
    checkOutput("rst_pix_x", pix_x, 0);
    checkOutput("rst_pix_last", pix_last, 0);
    doReset();

    $display("[TB] frame 2x2 after reset");
    applyStimulus(2, 2, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
